// File: rtl/reg_hazard_scoreboard.sv
// Decode-stage register hazard scoreboard with per-register writeback
// countdowns and a sticky check of the actual writeback stream.
module reg_hazard_scoreboard #(
  parameter int NREG = 8,
  parameter int LATW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [2:0]      issue_dst,
  input  logic [LATW-1:0] issue_lat,
  input  logic            src1_used,
  input  logic [2:0]      src1_sel,
  input  logic            src2_used,
  input  logic [2:0]      src2_sel,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [2:0]      wb_sel,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic            err
);

  logic [LATW-1:0] cnt_q [NREG];
  logic [LATW-1:0] cnt_d [NREG];
  logic            err_q;
  logic            err_d;

  logic            hz1;
  logic            hz2;
  logic            acc;
  logic            wr_acc;
  logic            lat0;
  logic [LATW-1:0] lat_eff;
  logic [NREG-1:0] exp_wb;
  logic            mism;
  logic            multi;

  // A count of 1 is the writeback cycle itself, which the regfile bypass covers.
  always_comb begin
    hz1   = src1_used & (cnt_q[src1_sel] >= LATW'(2));
    hz2   = src2_used & (cnt_q[src2_sel] >= LATW'(2));
    stall = hz1 | hz2;
  end

  always_comb begin
    acc     = issue_valid & ~stall & ~flush;
    wr_acc  = acc & issue_wr;
    lat0    = wr_acc & (issue_lat == '0);
    lat_eff = lat0 ? LATW'(1) : issue_lat;
  end

  always_comb begin
    exp_wb = '0;
    for (int r = 0; r < NREG; r++) begin
      exp_wb[r] = (cnt_q[r] == LATW'(1));
    end
    multi = |(exp_wb & (exp_wb - NREG'(1)));
    mism  = (wb_en & ~exp_wb[wb_sel]) |
            (~wb_en & (|exp_wb));
    err_d = err_q | mism | multi | lat0;
  end

  always_comb begin
    logic [LATW-1:0] dec;
    for (int r = 0; r < NREG; r++) begin
      dec = (cnt_q[r] == '0) ? '0 : cnt_q[r] - LATW'(1);
      if (flush) begin
        cnt_d[r] = '0;
      end else if (wr_acc && (issue_dst == 3'(r))
                   && (lat_eff > dec)) begin
        // Later writer to the same register dominates.
        cnt_d[r] = lat_eff;
      end else begin
        cnt_d[r] = dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) begin
      busy[r] = |cnt_q[r];
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Bench for reg_hazard_scoreboard: model tracks absolute writeback
// cycle per register and predicts stall, busy and err.
module tb_reg_hazard_scoreboard;
  localparam int NREG = 8;
  localparam int LATW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic            issue_wr;
  logic [2:0]      issue_dst;
  logic [LATW-1:0] issue_lat;
  logic            src1_used;
  logic [2:0]      src1_sel;
  logic            src2_used;
  logic [2:0]      src2_sel;
  logic            flush;
  logic            wb_en;
  logic [2:0]      wb_sel;
  logic            stall;
  logic [NREG-1:0] busy;
  logic            err;

  always #5 clk = ~clk;

  reg_hazard_scoreboard #(.NREG(NREG), .LATW(LATW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_dst(issue_dst), .issue_lat(issue_lat),
    .src1_used(src1_used), .src1_sel(src1_sel),
    .src2_used(src2_used), .src2_sel(src2_sel),
    .flush(flush), .wb_en(wb_en), .wb_sel(wb_sel),
    .stall(stall), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;
  // Absolute cycle in which each register's pending write lands.
  int wbt [NREG];
  int now = 0;
  bit merr;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    return (src1_used && wbt[src1_sel] > now) ||
           (src2_used && wbt[src2_sel] > now);
  endfunction

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b = '0;
    for (int r = 0; r < NREG; r++) b[r] = (wbt[r] >= now);
    return b;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NREG; r++) wbt[r] = -100;
    merr = 1'b0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr = 0; issue_dst = 0;
    issue_lat = 1; src1_used = 0; src1_sel = 0;
    src2_used = 0; src2_sel = 0; flush = 0;
    wb_en = 0; wb_sel = 0;
  endtask

  task automatic issue(input int dst, input int lat);
    issue_valid = 1; issue_wr = 1;
    issue_dst = 3'(dst); issue_lat = LATW'(lat);
  endtask

  task automatic wb_auto();
    wb_en = 0; wb_sel = 0;
    for (int r = NREG - 1; r >= 0; r--)
      if (wbt[r] == now) begin
        wb_en = 1; wb_sel = 3'(r);
      end
  endtask

  task automatic settle();
    @(negedge clk);
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("busy", 32'(busy), 32'(m_busy()));
    chk("err", 32'(err), 32'(merr));
  endtask

  task automatic edge_();
    int n = 0;
    int lat;
    bit acc;
    for (int r = 0; r < NREG; r++) if (wbt[r] == now) n++;
    if ((wb_en && wbt[wb_sel] != now) ||
        (!wb_en && n > 0) || n > 1) merr = 1;
    acc = issue_valid && !m_stall() && !flush;
    if (flush) begin
      for (int r = 0; r < NREG; r++) wbt[r] = -100;
    end else if (acc && issue_wr) begin
      lat = int'(issue_lat);
      if (lat == 0) begin
        lat = 1; merr = 1;
      end
      if (now + lat > wbt[issue_dst]) wbt[issue_dst] = now + lat;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic cyc();
    settle();
    edge_();
  endtask

  task automatic async_reset();
    #1 rst = 0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_err", 32'(err), 0);
    m_reset();
    rst = 1;
  endtask

  initial begin
    idle();
    m_reset();
    rst = 0;
    #2;
    chk("por_busy", 32'(busy), 0);
    chk("por_err", 32'(err), 0);
    @(posedge clk);
    #1 rst = 1;

    // Preload, then reset mid-cycle.
    issue(2, 6); cyc();
    issue(4, 7); src1_used = 1; src1_sel = 0; cyc();
    idle(); src1_used = 1; src1_sel = 2;
    settle();
    chk("pre_busy", 32'(busy), 32'h14);
    edge_();
    async_reset();
    idle(); cyc();

    // RAW on r3 with latency 3.
    issue(3, 3); cyc();
    idle(); src1_used = 1; src1_sel = 3;
    settle(); chk("raw_T", 32'(stall), 1); edge_();
    settle(); chk("raw_T1", 32'(stall), 1); edge_();
    wb_en = 1; wb_sel = 3;
    settle(); chk("raw_T2", 32'(stall), 0); edge_();
    wb_en = 0;
    settle(); chk("raw_idle", 32'(busy[3]), 0);
    chk("raw_err", 32'(err), 0); edge_();

    // WAW on r5: first writer's slot must stand.
    idle(); issue(5, 4); cyc();
    idle(); issue(5, 2); wb_auto(); cyc();
    for (int i = 0; i < 5; i++) begin
      idle(); wb_auto(); cyc();
    end
    settle(); chk("waw_err", 32'(err), 0); edge_();

    // Stall blocks issue.
    idle(); issue(2, 3); cyc();
    idle(); src2_used = 1; src2_sel = 2; issue(6, 2);
    settle(); chk("blk_stall", 32'(stall), 1); edge_();
    idle();
    settle(); chk("blk_busy6", 32'(busy[6]), 0); edge_();
    idle(); wb_auto(); cyc();
    idle(); cyc();

    // Flush with r1 in writeback and r4 pending.
    idle(); issue(1, 2); cyc();
    idle(); issue(4, 3); cyc();
    idle(); flush = 1; wb_en = 1; wb_sel = 1;
    settle(); chk("fl_pre", 32'(busy), 32'h12); edge_();
    idle();
    settle(); chk("fl_busy", 32'(busy), 0);
    chk("fl_err", 32'(err), 0); edge_();

    // Missing writeback on r7 is sticky.
    idle(); issue(7, 1); cyc();
    idle(); cyc();
    for (int i = 0; i < 10; i++) begin
      settle(); chk("sticky", 32'(err), 1); edge_();
    end
    async_reset();
    idle(); cyc();

    // Randomized segments separated by resets.
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 60; i++) begin
        idle();
        issue_valid = ($urandom_range(1, 0) == 1);
        issue_wr = ($urandom_range(4, 0) != 0);
        issue_dst = 3'($urandom_range(7, 0));
        issue_lat = ($urandom_range(19, 0) == 0) ? '0 :
                    LATW'($urandom_range(7, 1));
        src1_used = ($urandom_range(1, 0) == 1);
        src1_sel = 3'($urandom_range(7, 0));
        src2_used = ($urandom_range(1, 0) == 1);
        src2_sel = 3'($urandom_range(7, 0));
        flush = ($urandom_range(24, 0) == 0);
        if ($urandom_range(9, 0) != 0) begin
          wb_auto();
        end else begin
          wb_en = 1'($urandom_range(1, 0));
          wb_sel = 3'($urandom_range(7, 0));
        end
        cyc();
      end
      async_reset();
      idle(); cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
